// File: rtl/vault_pkg.sv
// Shared definitions for the keyed serial vault.
// Contents:
//   state_t - vault FSM encoding (receive, transmit, done, locked)
//   clog2   - ceiling log2, used to size the key/data/fail counters
package vault_pkg;

    typedef enum logic [1:0] {
        S_RX   = 2'd0,
        S_TX   = 2'd1,
        S_DONE = 2'd2,
        S_LOCK = 2'd3
    } state_t;

    // Smallest r with 2**r >= v; callers pass N+1 so a count of N fits.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int k = 0; k < 31; k++) begin
            if ((1 << k) < v) r = k + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// Async-reset shift register with synchronous clear, parallel load and
// single-bit shift. Priority: clear > load > shift.
// Parameters:
//   W     - register width (>= 2)
//   DIR   - 0: shift toward bit 0, din_i enters at MSB
//           1: shift toward MSB, din_i enters at bit 0
//   TAP_W - number of bits exposed on q_o, taken from the end that
//           leaves the register first (LSBs for DIR=0, MSBs for DIR=1)
// Ports:
//   clk, rst    - clock, async active-high reset
//   clr_i       - clear contents to zero
//   load_i      - load load_val_i
//   load_val_i  - parallel load value
//   shift_i     - shift by one, inserting din_i
//   din_i       - serial input bit
//   q_o         - register tap
module serial_shift_reg #(
    parameter int W     = 8,
    parameter bit DIR   = 1'b0,
    parameter int TAP_W = W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [W-1:0]     load_val_i,
    input  logic             shift_i,
    input  logic             din_i,
    output logic [TAP_W-1:0] q_o
);

    logic [W-1:0] sr_q;
    logic [W-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (clr_i) begin
            sr_d = '0;
        end else if (load_i) begin
            sr_d = load_val_i;
        end else if (shift_i) begin
            if (DIR == 1'b0) sr_d = {din_i, sr_q[W-1:1]};
            else             sr_d = {sr_q[W-2:0], din_i};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sr_q <= '0;
        else     sr_q <= sr_d;
    end

    generate
        if (DIR == 1'b0) begin : g_tap_lsb
            assign q_o = sr_q[TAP_W-1:0];
        end else begin : g_tap_msb
            assign q_o = sr_q[W-1 -: TAP_W];
        end
    endgenerate

endmodule

// File: rtl/keyed_serial_vault.sv
// Key-gated serial secret store. A key is shifted in LSB first on i while
// cs=0; a one-cycle cs=1 strobe evaluates it. On a match the secret DATA
// streams out on o, LSB first, one bit per following cs=0 cycle. MAX_FAILS
// consecutive bad keys lock the block until reset. cs=1 while streaming or
// after the stream aborts back to receive.
// Ports:
//   clk     - clock, rising edge
//   rst     - async active-high reset
//   cs      - 0 = shift cycle, 1 = strobe / evaluate / abort
//   i       - serial key bit
//   o       - serial secret bit (registered, out_sr[0])
//   o_valid - o carries a secret bit
//   locked  - lockout reached; cleared only by rst
module keyed_serial_vault
    import vault_pkg::*;
#(
    parameter int                KEY_W     = 32,
    parameter logic [KEY_W-1:0]  KEY       = 32'h1337beef,
    parameter int                DATA_W    = 256,
    parameter logic [DATA_W-1:0] DATA      = '0,
    parameter int                MAX_FAILS = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic cs,
    input  logic i,
    output logic o,
    output logic o_valid,
    output logic locked
);

    localparam int BCW = clog2(KEY_W + 1);
    localparam int TCW = clog2(DATA_W + 1);
    localparam int FCW = clog2(MAX_FAILS + 1);

    localparam logic [BCW-1:0] KEY_CNT  = BCW'(KEY_W);
    localparam logic [TCW-1:0] DATA_CNT = TCW'(DATA_W);
    localparam logic [FCW-1:0] FAIL_MAX = FCW'(MAX_FAILS);

    state_t         state_q, state_d;
    logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
    logic [TCW-1:0] tx_cnt_q, tx_cnt_d;
    logic [FCW-1:0] fail_cnt_q, fail_cnt_d;

    logic             key_shift, key_clr;
    logic             out_shift, out_clr, out_load;
    logic [KEY_W-1:0] key_sr;
    logic             out_lsb;
    logic             key_match;

    serial_shift_reg #(.W(KEY_W), .DIR(1'b0), .TAP_W(KEY_W)) u_key_sr (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (key_clr),
        .load_i     (1'b0),
        .load_val_i ('0),
        .shift_i    (key_shift),
        .din_i      (i),
        .q_o        (key_sr)
    );

    // Zeros shift in behind the secret, so the register is empty once the
    // stream completes; o therefore needs no extra gating outside S_TX.
    serial_shift_reg #(.W(DATA_W), .DIR(1'b0), .TAP_W(1)) u_out_sr (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (out_clr),
        .load_i     (out_load),
        .load_val_i (DATA),
        .shift_i    (out_shift),
        .din_i      (1'b0),
        .q_o        (out_lsb)
    );

    // Fewer than KEY_W bits never match, even if the low bits agree.
    assign key_match = (bit_cnt_q == KEY_CNT) && (key_sr == KEY);

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        tx_cnt_d   = tx_cnt_q;
        fail_cnt_d = fail_cnt_q;
        key_shift  = 1'b0;
        key_clr    = 1'b0;
        out_load   = 1'b0;
        out_shift  = 1'b0;
        out_clr    = 1'b0;
        case (state_q)
            S_RX: begin
                if (cs) begin
                    key_clr   = 1'b1;
                    bit_cnt_d = '0;
                    if (key_match) begin
                        out_load   = 1'b1;
                        tx_cnt_d   = DATA_CNT;
                        fail_cnt_d = '0;
                        state_d    = S_TX;
                    end else begin
                        fail_cnt_d = fail_cnt_q + 1'b1;
                        if (fail_cnt_d == FAIL_MAX) state_d = S_LOCK;
                    end
                end else begin
                    key_shift = 1'b1;
                    if (bit_cnt_q != KEY_CNT) bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            S_TX: begin
                if (cs) begin
                    out_clr  = 1'b1;
                    tx_cnt_d = '0;
                    state_d  = S_RX;
                end else begin
                    out_shift = 1'b1;
                    tx_cnt_d  = tx_cnt_q - 1'b1;
                    if (tx_cnt_q == TCW'(1)) state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (cs) begin
                    out_clr  = 1'b1;
                    tx_cnt_d = '0;
                    state_d  = S_RX;
                end
            end
            default: ;  // S_LOCK: sticky until reset
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_RX;
            bit_cnt_q  <= '0;
            tx_cnt_q   <= '0;
            fail_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_cnt_q   <= tx_cnt_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    assign o       = out_lsb;
    assign o_valid = (state_q == S_TX);
    assign locked  = (state_q == S_LOCK);

endmodule

// File: tb/tb_keyed_serial_vault.sv
// Directed bench for keyed_serial_vault: default-parameter instance plus a
// small KEY_W=8 / DATA_W=16 / MAX_FAILS=1 instance.
module tb_keyed_serial_vault;

    localparam logic [255:0] DATA  = {4{64'h0123456789abcdef}};
    localparam logic [31:0]  KEY   = 32'h1337beef;
    localparam logic [7:0]   KEY2  = 8'ha5;
    localparam logic [15:0]  DATA2 = 16'hbeef;

    logic clk = 1'b0;
    logic rst, cs, i;
    logic o, o_valid, locked;
    logic rst2, cs2, i2;
    logic o2, o_valid2, locked2;

    int checks = 0;
    int errors = 0;

    logic [255:0] w;
    int           vc;

    always #5 clk = ~clk;

    keyed_serial_vault #(
        .KEY_W(32), .KEY(KEY), .DATA_W(256), .DATA(DATA), .MAX_FAILS(3)
    ) dut (
        .clk(clk), .rst(rst), .cs(cs), .i(i),
        .o(o), .o_valid(o_valid), .locked(locked)
    );

    keyed_serial_vault #(
        .KEY_W(8), .KEY(KEY2), .DATA_W(16), .DATA(DATA2), .MAX_FAILS(1)
    ) dut2 (
        .clk(clk), .rst(rst2), .cs(cs2), .i(i2),
        .o(o2), .o_valid(o_valid2), .locked(locked2)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] v, input int n);
        for (int b = 0; b < n; b++) begin
            cs = 1'b0;
            i  = v[b];
            step();
        end
        i = 1'b0;
    endtask

    task automatic strobe();
        cs = 1'b1;
        step();
        cs = 1'b0;
    endtask

    task automatic rd(input int n, output logic [255:0] word, output int vcnt);
        word = '0;
        vcnt = 0;
        for (int k = 0; k < n; k++) begin
            word[k] = o;
            if (o_valid) vcnt++;
            cs = 1'b0;
            step();
        end
    endtask

    task automatic send2(input logic [7:0] v);
        for (int b = 0; b < 8; b++) begin
            cs2 = 1'b0;
            i2  = v[b];
            step();
        end
        i2 = 1'b0;
    endtask

    task automatic strobe2();
        cs2 = 1'b1;
        step();
        cs2 = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cs = 1'b0; i = 1'b0;
        rst2 = 1'b1; cs2 = 1'b0; i2 = 1'b0;
        #12;
        chk("rst_o", o, 0);
        chk("rst_ovalid", o_valid, 0);
        chk("rst_locked", locked, 0);
        chk("rst_state", dut.state_q, 0);
        rst = 1'b0; rst2 = 1'b0;
        step();

        // 1: correct key, full stream
        send(KEY, 32);
        strobe();
        chk("t1_first_valid", o_valid, 1);
        rd(256, w, vc);
        chk("t1_data", w, DATA);
        chk("t1_vcnt", vc, 256);
        chk("t1_after_valid", o_valid, 0);
        chk("t1_after_o", o, 0);
        chk("t1_done_state", dut.state_q, 2);
        strobe();
        chk("t1_abort_state", dut.state_q, 0);

        // 2: near-miss key then correct key
        send(32'h1337beee, 32);
        strobe();
        chk("t2_bad_o", o, 0);
        chk("t2_bad_valid", o_valid, 0);
        chk("t2_fail1", dut.fail_cnt_q, 1);
        send(KEY, 32);
        strobe();
        rd(256, w, vc);
        chk("t2_data", w, DATA);
        chk("t2_fail0", dut.fail_cnt_q, 0);
        strobe();

        // 3: lockout
        send(32'h00000000, 32); strobe();
        chk("t3_fail1", dut.fail_cnt_q, 1);
        send(32'hffffffff, 32); strobe();
        chk("t3_fail2", dut.fail_cnt_q, 2);
        chk("t3_not_locked", locked, 0);
        send(32'h1337beed, 32); strobe();
        chk("t3_locked", locked, 1);
        send(KEY, 32); strobe();
        rd(256, w, vc);
        chk("t3_lock_data", w, 0);
        chk("t3_lock_vcnt", vc, 0);
        chk("t3_still_locked", locked, 1);
        rst = 1'b1;
        #1;
        chk("t3_rst_unlock", locked, 0);
        chk("t3_rst_fail", dut.fail_cnt_q, 0);
        #1;
        rst = 1'b0;
        step();
        send(KEY, 32); strobe();
        rd(256, w, vc);
        chk("t3_post_rst_data", w, DATA);
        strobe();

        // 4: short key fails, over-long key with junk prefix succeeds
        send(KEY, 31); strobe();
        chk("t4_short_valid", o_valid, 0);
        chk("t4_short_fail", dut.fail_cnt_q, 1);
        send({KEY, 8'h5c}, 40); strobe();
        chk("t4_long_valid", o_valid, 1);
        rd(256, w, vc);
        chk("t4_long_data", w, DATA);
        chk("t4_long_fail", dut.fail_cnt_q, 0);
        strobe();

        // 5: abort mid-stream then restart
        send(KEY, 32); strobe();
        rd(100, w, vc);
        chk("t5_part_data", w[99:0], DATA[99:0]);
        strobe();
        chk("t5_abort_o", o, 0);
        chk("t5_abort_valid", o_valid, 0);
        chk("t5_abort_state", dut.state_q, 0);
        chk("t5_abort_fail", dut.fail_cnt_q, 0);
        send(KEY, 32); strobe();
        rd(256, w, vc);
        chk("t5_restart_data", w, DATA);
        strobe();

        // 6: async reset mid-stream
        send(KEY, 32); strobe();
        rd(50, w, vc);
        chk("t6_part_data", w[49:0], DATA[49:0]);
        chk("t6_pre_valid", o_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_o", o, 0);
        chk("t6_async_valid", o_valid, 0);
        #1 rst = 1'b0;
        step();
        chk("t6_state", dut.state_q, 0);

        // 6 (cont.): small instance, single bad key locks
        send2(KEY2); strobe2();
        chk("s_valid", o_valid2, 1);
        w = '0;
        vc = 0;
        for (int k = 0; k < 16; k++) begin
            w[k] = o2;
            if (o_valid2) vc++;
            step();
        end
        chk("s_data", w[15:0], DATA2);
        chk("s_vcnt", vc, 16);
        chk("s_done_valid", o_valid2, 0);
        strobe2();
        send2(8'h5a); strobe2();
        chk("s_locked", locked2, 1);
        send2(KEY2); strobe2();
        chk("s_lock_valid", o_valid2, 0);
        chk("s_lock_o", o2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
